fx2fp8_encoder: RTL and testbench

- Streaming converter from signed fixed-point to the fp8 operand format used by the fp8 adder: sign[7], biased exponent[6:4], mantissa[3:0] with hidden leading 1; 8'h00 is zero.
- Sits upstream of the adder and produces its operands from the fixed-point datapath.
- Normalizes iteratively, one left shift per cycle, behind valid/ready handshakes on both sides.

---
 rtl/fx2fp8_encoder.sv | 140 ++++++++++++++
 tb/tb_fx2fp8_encoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fx2fp8_encoder.sv
// ============================================================================
//  Module      : fx2fp8_encoder
//  Description : Streaming signed fixed-point to fp8 converter; normalizes one
//                bit per cycle behind valid/ready handshakes.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fx2fp8_encoder #(
    parameter int IN_W      = 12,
    parameter int FRAC_BITS = 4,
    parameter int BIAS      = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            out_sat,
    output logic            out_uflow
);

    localparam int SW = $clog2(IN_W);
    localparam int EW = SW + 4;
    localparam logic signed [EW-1:0] C_EXP_TOP = EW'(IN_W - 1 - FRAC_BITS + BIAS);
    localparam logic signed [EW-1:0] C_EXP_MAX = EW'(7);
    localparam logic signed [EW-1:0] C_EXP_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ABS  = 3'd1,
        S_NORM = 3'd2,
        S_PACK = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            sign_q, sign_d;
    logic [IN_W-1:0] m_q, m_d;
    logic [SW-1:0]   s_q, s_d;
    logic [7:0]      data_q, data_d;
    logic            sat_q, sat_d;
    logic            uflow_q, uflow_d;

    logic signed [EW-1:0] w_exp;
    logic [3:0]           w_mant;

    // Leading-one position is IN_W-1-s, so the exponent drops by one per shift.
    assign w_exp  = C_EXP_TOP - $signed({{(EW-SW){1'b0}}, s_q});
    assign w_mant = m_q[IN_W-2 -: 4];

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        m_d     = m_q;
        s_d     = s_q;
        data_d  = data_q;
        sat_d   = sat_q;
        uflow_d = uflow_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    m_d     = in_data;
                    state_d = S_ABS;
                end
            end
            S_ABS: begin
                // Unsigned negation maps the most negative input to 2^(IN_W-1).
                sign_d  = m_q[IN_W-1];
                m_d     = m_q[IN_W-1] ? (~m_q + IN_W'(1)) : m_q;
                s_d     = '0;
                state_d = S_NORM;
            end
            S_NORM: begin
                if ((m_q == '0) || m_q[IN_W-1]) begin
                    state_d = S_PACK;
                end else begin
                    m_d = m_q << 1;
                    s_d = s_q + SW'(1);
                end
            end
            S_PACK: begin
                sat_d   = 1'b0;
                uflow_d = 1'b0;
                if (m_q == '0) begin
                    data_d = 8'h00;
                end else if (w_exp > C_EXP_MAX) begin
                    data_d = {sign_q, 7'h7F};
                    sat_d  = 1'b1;
                end else if ((w_exp < C_EXP_ZERO) ||
                             ((w_exp == C_EXP_ZERO) && (w_mant == 4'h0))) begin
                    data_d  = 8'h00;
                    uflow_d = 1'b1;
                end else begin
                    data_d = {sign_q, w_exp[2:0], w_mant};
                end
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            m_q     <= '0;
            s_q     <= '0;
            data_q  <= 8'h00;
            sat_q   <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            m_q     <= m_d;
            s_q     <= s_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            uflow_q <= uflow_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign out_data  = data_q;
    assign out_sat   = sat_q;
    assign out_uflow = uflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fx2fp8_encoder.sv
// ============================================================================
//  Module      : tb_fx2fp8_encoder
//  Description : Self-checking bench for fx2fp8_encoder: directed table,
//                backpressure, mid-operation reset and randomized words.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fx2fp8_encoder;

    localparam int IN_W      = 12;
    localparam int FRAC_BITS = 4;
    localparam int BIAS      = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic            out_sat;
    logic            out_uflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fx2fp8_encoder #(
        .IN_W     (IN_W),
        .FRAC_BITS(FRAC_BITS),
        .BIAS     (BIAS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .out_uflow(out_uflow)
    );

    typedef struct packed {
        logic [11:0] d;
        logic [7:0]  q;
        logic        sat;
        logic        uf;
        logic [5:0]  lat;
        logic [4:0]  hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: real-valued magnitude, leading-one position by search,
    // truncated 4-bit fraction below it.
    function automatic void model(input logic [11:0] d, output logic [7:0] q,
                                  output logic sat, output logic uf, output int lat);
        int v, a, p, e, mant;
        v   = $signed(d);
        a   = (v < 0) ? -v : v;
        q   = 8'h00;
        sat = 1'b0;
        uf  = 1'b0;
        lat = 4;
        if (a == 0) return;
        p = 0;
        while ((a >> (p + 1)) != 0) p++;
        lat  = 4 + (IN_W - 1 - p);
        e    = p - FRAC_BITS + BIAS;
        mant = ((a << 4) >> p) & 15;
        if (e > 7) begin
            q   = {d[11], 7'h7F};
            sat = 1'b1;
        end else if (e < 0 || (e == 0 && mant == 0)) begin
            uf = 1'b1;
        end else begin
            q = {d[11], 3'(e), 4'(mant)};
        end
    endfunction

    task automatic run_one(input logic [11:0] d, input logic [7:0] eq, input logic es,
                           input logic eu, input int elat, input int hold, input string tag);
        int lat;
        logic [7:0] q0;
        logic s0, u0;
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!in_ready) begin
            check({tag, " wait_idle"}, in_ready, 1);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 40) begin
            check({tag, " busy_in_ready"}, in_ready, 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 12'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, elat);
        if (!out_valid) begin
            in_valid  = 1'b0;
            out_ready = 1'b0;
            return;
        end
        check({tag, " data"}, out_data, eq);
        check({tag, " sat"}, out_sat, es);
        check({tag, " uflow"}, out_uflow, eu);
        q0 = out_data;
        s0 = out_sat;
        u0 = out_uflow;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 12'($urandom);
            @(negedge clk);
            check({tag, " hold_valid"}, out_valid, 1);
            check({tag, " hold_data"}, {out_data, out_sat, out_uflow}, {q0, s0, u0});
            check({tag, " hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check({tag, " post_valid"}, out_valid, 0);
        check({tag, " post_in_ready"}, in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        logic [11:0] d;
        logic [7:0]  q;
        logic        s, u;
        int          l;

        vecs[0] = '{d: 12'h010, q: 8'h30, sat: 1'b0, uf: 1'b0, lat: 6'd11, hold: 5'd0};
        vecs[1] = '{d: 12'hFCC, q: 8'hCA, sat: 1'b0, uf: 1'b0, lat: 6'd10, hold: 5'd1};
        vecs[2] = '{d: 12'h7FF, q: 8'h7F, sat: 1'b1, uf: 1'b0, lat: 6'd5,  hold: 5'd0};
        vecs[3] = '{d: 12'h800, q: 8'hFF, sat: 1'b1, uf: 1'b0, lat: 6'd4,  hold: 5'd2};
        vecs[4] = '{d: 12'h001, q: 8'h00, sat: 1'b0, uf: 1'b1, lat: 6'd15, hold: 5'd0};
        vecs[5] = '{d: 12'h002, q: 8'h00, sat: 1'b0, uf: 1'b1, lat: 6'd14, hold: 5'd1};
        vecs[6] = '{d: 12'h003, q: 8'h08, sat: 1'b0, uf: 1'b0, lat: 6'd14, hold: 5'd0};
        vecs[7] = '{d: 12'h000, q: 8'h00, sat: 1'b0, uf: 1'b0, lat: 6'd4,  hold: 5'd3};
        vecs[8] = '{d: 12'h010, q: 8'h30, sat: 1'b0, uf: 1'b0, lat: 6'd11, hold: 5'd20};
        vecs[9] = '{d: 12'hFFF, q: 8'h00, sat: 1'b0, uf: 1'b1, lat: 6'd15, hold: 5'd0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 8'h00);
        check("reset flags", {out_sat, out_uflow}, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_one(vecs[i].d, vecs[i].q, vecs[i].sat, vecs[i].uf, int'(vecs[i].lat),
                    int'(vecs[i].hold), $sformatf("vec%0d(%03h)", i, vecs[i].d));
        end

        // Reset while normalizing the minimum nonzero input.
        in_valid = 1'b1;
        in_data  = 12'h001;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst in_ready", in_ready, 1);
        check("midrst out_data", out_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_one(12'h010, 8'h30, 1'b0, 1'b0, 11, 0, "after_reset");

        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) d = 12'($urandom);
            else            d = 12'($signed(6'($urandom)));
            model(d, q, s, u, l);
            run_one(d, q, s, u, l, int'($urandom_range(0, 3)), $sformatf("rnd%0d(%03h)", i, d));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
